// File: rtl/sram_loader.sv
// ---------------------------------------------------------------------------
// sram_loader
//
// Host-side SRAM programming engine. While a load session runs, the 8051 is
// held in reset and a byte stream arriving over a valid/ready handshake is
// written into the external 128 KB SRAM at consecutive 17-bit addresses. Each
// byte can be read back and compared; any mismatch sets a sticky error flag.
//
// Every output comes straight from a flop. The output flops are loaded from
// the *next* state, so each strobe is valid for exactly the cycles the FSM
// spends in the state that owns it, and cannot glitch.
//
// Parameters
//   WE_CYCLES     clocks sram_we_no is held low per byte (>= 1)
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-high reset
//   ld_start_i          one-cycle session start (ignored while busy)
//   ld_base_i17         first SRAM address   (latched on start)
//   ld_len_i17          byte count, 0=empty  (latched on start)
//   ld_verify_i         read-back compare    (latched on start)
//   ld_vld_i/ld_dat_i8  input byte stream, transfer on ld_vld_i & ld_rdy_o
//   ld_rdy_o            loader can take a byte
//   ld_busy_o           session in progress
//   ld_done_o           one-cycle end-of-session pulse
//   ld_err_o            sticky verify mismatch, cleared by an accepted start
//   mcu_rst_o           MCU reset request, high while a session runs
//   sram_addr_o17       SRAM address
//   sram_dat_o8         SRAM write data
//   sram_dat_oe_o       drive sram_dat_o8 onto the shared SRAM data bus
//   sram_dat_i8         SRAM read data
//   sram_we_no          SRAM write enable, active low
//   sram_oe_no          SRAM output enable, active low
// ---------------------------------------------------------------------------
module sram_loader #(
    parameter int WE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ld_start_i,
    input  logic [16:0] ld_base_i17,
    input  logic [16:0] ld_len_i17,
    input  logic        ld_verify_i,
    input  logic        ld_vld_i,
    input  logic [7:0]  ld_dat_i8,
    output logic        ld_rdy_o,
    output logic        ld_busy_o,
    output logic        ld_done_o,
    output logic        ld_err_o,

    output logic        mcu_rst_o,

    output logic [16:0] sram_addr_o17,
    output logic [7:0]  sram_dat_o8,
    output logic        sram_dat_oe_o,
    input  logic [7:0]  sram_dat_i8,
    output logic        sram_we_no,
    output logic        sram_oe_no
);

    // One counter times both the WRITE pulse and the two-cycle VREAD; it must
    // reach max(WE_CYCLES-1, 1).
    localparam int CNT_W = $clog2(WE_CYCLES + 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_VREAD,
        S_VCMP,
        S_NEXT,
        S_DONE
    } state_e;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [16:0]        addr_q,   addr_d;
    logic [16:0]        rem_q,    rem_d;     // bytes still to be written
    logic [7:0]         dat_q,    dat_d;     // byte being written
    logic [7:0]         rd_q,     rd_d;      // byte read back for compare
    logic               vfy_q,    vfy_d;
    logic               err_q,    err_d;

    // Registered control outputs, loaded from the next state
    logic               rdy_q,    rdy_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               mcu_rst_q, mcu_rst_d;
    logic               we_n_q,   we_n_d;
    logic               oe_n_q,   oe_n_d;
    logic               dat_oe_q, dat_oe_d;

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        rd_d    = rd_q;
        vfy_d   = vfy_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ld_start_i) begin
                    addr_d  = ld_base_i17;
                    rem_d   = ld_len_i17;
                    vfy_d   = ld_verify_i;
                    err_d   = 1'b0;
                    state_d = (ld_len_i17 == 17'd0) ? S_DONE : S_WAIT;
                end
            end

            // rdy_q is high exactly while in WAIT, so a start that coincides
            // with ld_vld_i in IDLE can never take a byte.
            S_WAIT: begin
                if (ld_vld_i && rdy_q) begin
                    dat_d   = ld_dat_i8;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Data stays on the bus one clock past the WE rising edge.
            S_HOLD: begin
                cnt_d   = '0;
                state_d = vfy_q ? S_VREAD : S_NEXT;
            end

            // The first VREAD cycle covers SRAM output-enable access time;
            // the bus is sampled on the edge that ends the second one.
            S_VREAD: begin
                if (cnt_q == CNT_W'(1)) begin
                    rd_d    = sram_dat_i8;
                    state_d = S_VCMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_VCMP: begin
                if (rd_q != dat_q) begin
                    err_d = 1'b1;
                end
                state_d = S_NEXT;
            end

            // Address wraps naturally modulo 2^17.
            S_NEXT: begin
                addr_d  = addr_q + 17'd1;
                rem_d   = rem_q - 17'd1;
                state_d = (rem_q == 17'd1) ? S_DONE : S_WAIT;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state, so each registered strobe lines up
    // with the cycle the FSM spends in its state. Only WRITE lowers WE and
    // only VREAD lowers OE, so the two can never overlap, and the data
    // driver is off throughout VREAD.
    // -----------------------------------------------------------------------
    always_comb begin
        rdy_d     = (state_d == S_WAIT);
        busy_d    = (state_d != S_IDLE);
        mcu_rst_d = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        we_n_d    = (state_d != S_WRITE);
        oe_n_d    = (state_d != S_VREAD);
        dat_oe_d  = (state_d == S_SETUP) || (state_d == S_WRITE) ||
                    (state_d == S_HOLD);
    end

    // -----------------------------------------------------------------------
    // Registers. Reset puts the SRAM strobes inactive and releases the data
    // bus immediately, abandoning any session in flight; the MCU stays in
    // reset until the first clock after rst_i falls.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            dat_q     <= '0;
            rd_q      <= '0;
            vfy_q     <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mcu_rst_q <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            dat_oe_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            dat_q     <= dat_d;
            rd_q      <= rd_d;
            vfy_q     <= vfy_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mcu_rst_q <= mcu_rst_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ld_rdy_o      = rdy_q;
    assign ld_busy_o     = busy_q;
    assign ld_done_o     = done_q;
    assign ld_err_o      = err_q;
    assign mcu_rst_o     = mcu_rst_q;
    assign sram_addr_o17 = addr_q;
    assign sram_dat_o8   = dat_q;
    assign sram_dat_oe_o = dat_oe_q;
    assign sram_we_no    = we_n_q;
    assign sram_oe_no    = oe_n_q;

    // -----------------------------------------------------------------------
    // Bus-safety properties
    // -----------------------------------------------------------------------
    a_strobes_exclusive: assert property (
        @(posedge clk_i) disable iff (rst_i) !(!sram_we_no && !sram_oe_no));

    a_no_drive_on_read: assert property (
        @(posedge clk_i) disable iff (rst_i) !(!sram_oe_no && sram_dat_oe_o));

    a_done_while_busy: assert property (
        @(posedge clk_i) disable iff (rst_i) ld_done_o |-> ld_busy_o);

endmodule

// File: tb/tb_sram_loader.sv
// ---------------------------------------------------------------------------
// tb_sram_loader
//
// Scoreboard bench for sram_loader. Stimulus tasks push the expected SRAM
// writes ({addr, data}) and expected end-of-session error flags into queues
// before driving a session; independent monitors pop and compare whenever
// the DUT completes a write (WE rising) or pulses ld_done_o. A behavioural
// SRAM model stores the written bytes and can force data bit 3 low on reads.
// ---------------------------------------------------------------------------
module tb_sram_loader;

    localparam int WE     = 2;
    localparam int GAP_NV = WE + 3;   // accept edge -> next WAIT, no verify
    localparam int GAP_V  = WE + 6;   // accept edge -> next WAIT, verify

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ld_start_i = 1'b0;
    logic [16:0] ld_base_i17 = '0;
    logic [16:0] ld_len_i17 = '0;
    logic        ld_verify_i = 1'b0;
    logic        ld_vld_i = 1'b0;
    logic [7:0]  ld_dat_i8 = '0;
    logic        ld_rdy_o, ld_busy_o, ld_done_o, ld_err_o, mcu_rst_o;
    logic [16:0] sram_addr_o17;
    logic [7:0]  sram_dat_o8;
    logic        sram_dat_oe_o;
    logic [7:0]  sram_dat_i8;
    logic        sram_we_no, sram_oe_no;

    sram_loader #(.WE_CYCLES(WE)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ld_start_i    (ld_start_i),
        .ld_base_i17   (ld_base_i17),
        .ld_len_i17    (ld_len_i17),
        .ld_verify_i   (ld_verify_i),
        .ld_vld_i      (ld_vld_i),
        .ld_dat_i8     (ld_dat_i8),
        .ld_rdy_o      (ld_rdy_o),
        .ld_busy_o     (ld_busy_o),
        .ld_done_o     (ld_done_o),
        .ld_err_o      (ld_err_o),
        .mcu_rst_o     (mcu_rst_o),
        .sram_addr_o17 (sram_addr_o17),
        .sram_dat_o8   (sram_dat_o8),
        .sram_dat_oe_o (sram_dat_oe_o),
        .sram_dat_i8   (sram_dat_i8),
        .sram_we_no    (sram_we_no),
        .sram_oe_no    (sram_oe_no)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter; read only on negative edges.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Checking infrastructure
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [24:0] wq[$];         // expected writes {addr17, data8}
    bit          exp_done_q[$]; // expected ld_err_o at each done pulse

    // -----------------------------------------------------------------------
    // SRAM model
    // -----------------------------------------------------------------------
    logic [7:0] mem [0:131071];
    bit         stuck_en = 1'b0;
    logic [7:0] rd_mask;

    assign rd_mask     = stuck_en ? 8'hF7 : 8'hFF;
    assign sram_dat_i8 = sram_oe_no ? 8'h00 : (mem[sram_addr_o17] & rd_mask);

    // Write monitor: an asynchronous SRAM commits on the WE rising edge.
    always @(posedge sram_we_no) begin
        if (!rst_i) begin
            check(wq.size() != 0, "unexpected_write", {15'd0, sram_addr_o17}, 0);
            if (wq.size() != 0) begin
                logic [24:0] e;
                e = wq.pop_front();
                check(sram_addr_o17 == e[24:8], "write_addr", {15'd0, sram_addr_o17}, {15'd0, e[24:8]});
                check(sram_dat_o8 == e[7:0], "write_data", {24'd0, sram_dat_o8}, {24'd0, e[7:0]});
                check(sram_dat_oe_o, "write_dat_oe", {31'd0, sram_dat_oe_o}, 1);
            end
            mem[sram_addr_o17] = sram_dat_o8;
        end
    end

    // Cycle monitor: strobe widths, bus invariants, done pulses.
    int we_run = 0, oe_run = 0;
    int we_total = 0, oe_total = 0;
    bit rst_prev = 1'b1, done_prev = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i || rst_prev) begin
            we_run    = 0;
            oe_run    = 0;
            done_prev = 1'b0;
        end else begin
            check(sram_we_no || sram_oe_no, "strobes_overlap", {30'd0, sram_we_no, sram_oe_no}, 32'h3);
            check(sram_oe_no || !sram_dat_oe_o, "dat_oe_during_read", {31'd0, sram_dat_oe_o}, 0);
            check(mcu_rst_o == ld_busy_o, "mcu_rst_tracks_busy", {31'd0, mcu_rst_o}, {31'd0, ld_busy_o});
            if (!sram_we_no) begin
                we_run++;
                we_total++;
            end else if (we_run != 0) begin
                check(we_run == WE, "we_low_width", we_run, WE);
                we_run = 0;
            end
            if (!sram_oe_no) begin
                oe_run++;
                oe_total++;
            end else if (oe_run != 0) begin
                check(oe_run == 2, "oe_low_width", oe_run, 2);
                oe_run = 0;
            end
            if (ld_done_o) begin
                check(!done_prev, "done_width", 2, 1);
                check(ld_busy_o, "busy_at_done", {31'd0, ld_busy_o}, 1);
                check(exp_done_q.size() != 0, "unexpected_done", 1, 0);
                if (exp_done_q.size() != 0) begin
                    bit e;
                    e = exp_done_q.pop_front();
                    check(ld_err_o == e, "err_at_done", {31'd0, ld_err_o}, {31'd0, e});
                end
            end
            done_prev = ld_done_o;
        end
        rst_prev = rst_i;
    end

    // -----------------------------------------------------------------------
    // Stimulus tasks
    // -----------------------------------------------------------------------
    int last_acc_edge = 0;  // cyc value produced by the most recent accept edge

    task automatic check_reset_values();
        check(!ld_rdy_o,  "rst_rdy",    {31'd0, ld_rdy_o}, 0);
        check(!ld_busy_o, "rst_busy",   {31'd0, ld_busy_o}, 0);
        check(!ld_done_o, "rst_done",   {31'd0, ld_done_o}, 0);
        check(!ld_err_o,  "rst_err",    {31'd0, ld_err_o}, 0);
        check(sram_addr_o17 == 17'd0, "rst_addr", {15'd0, sram_addr_o17}, 0);
        check(sram_dat_o8 == 8'd0, "rst_dat", {24'd0, sram_dat_o8}, 0);
        check(!sram_dat_oe_o, "rst_dat_oe", {31'd0, sram_dat_oe_o}, 0);
        check(sram_we_no, "rst_we_n",   {31'd0, sram_we_no}, 1);
        check(sram_oe_no, "rst_oe_n",   {31'd0, sram_oe_no}, 1);
        check(mcu_rst_o,  "rst_mcu_rst", {31'd0, mcu_rst_o}, 1);
    endtask

    task automatic do_start(input logic [16:0] base, input logic [16:0] len,
                            input bit vfy, input bit with_vld);
        @(negedge clk_i);
        ld_start_i  = 1'b1;
        ld_base_i17 = base;
        ld_len_i17  = len;
        ld_verify_i = vfy;
        if (with_vld) begin
            ld_vld_i  = 1'b1;
            ld_dat_i8 = 8'hEE;
        end
        @(posedge clk_i);
        #1;
        ld_start_i = 1'b0;
        ld_vld_i   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap, input bit chk_gap);
        int waited = 0;
        bit got = 1'b0;
        while (!got && waited < 100) begin
            @(negedge clk_i);
            if (ld_rdy_o) got = 1'b1;
            else waited++;
        end
        check(got, "rdy_timeout", waited, 0);
        if (got) begin
            if (chk_gap)
                check(cyc - last_acc_edge == gap, "byte_period", cyc - last_acc_edge, gap);
            ld_vld_i      = 1'b1;
            ld_dat_i8     = d;
            last_acc_edge = cyc + 1;
            @(posedge clk_i);
            #1;
            ld_vld_i = 1'b0;
        end
    endtask

    task automatic finish_session(input int gap);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk_i);
            if (ld_done_o) seen = 1'b1;
            else n++;
        end
        check(seen && (cyc - last_acc_edge == gap), "done_latency", cyc - last_acc_edge, gap);
        @(negedge clk_i);
        check(!ld_busy_o && !mcu_rst_o && !ld_done_o, "idle_after_done",
              {29'd0, ld_busy_o, mcu_rst_o, ld_done_o}, 0);
        check(wq.size() == 0, "writes_drained", wq.size(), 0);
        check(exp_done_q.size() == 0, "done_drained", exp_done_q.size(), 0);
    endtask

    // Full session: push expectations, start, stream up to four bytes
    // (byte i = bytes[8*i +: 8]) back to back, then wait for the end.
    task automatic run_session(input logic [16:0] base, input int len, input bit vfy,
                               input logic [31:0] bytes, input bit exp_err);
        int gap;
        logic [16:0] a;
        gap = vfy ? GAP_V : GAP_NV;
        a   = base;
        exp_done_q.push_back(exp_err);
        for (int i = 0; i < len; i++) begin
            wq.push_back({a, bytes[8*i +: 8]});
            a = a + 17'd1;
        end
        do_start(base, 17'(len), vfy, 1'b0);
        @(negedge clk_i);
        check(ld_rdy_o && ld_busy_o && mcu_rst_o, "start_to_rdy",
              {29'd0, ld_rdy_o, ld_busy_o, mcu_rst_o}, 32'h7);
        for (int i = 0; i < len; i++)
            send(bytes[8*i +: 8], gap, i > 0);
        finish_session(gap);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int snap_we, snap_oe, n;
        bit rdy_held;

        // Power-on reset and release.
        @(negedge clk_i);
        check_reset_values();
        #2 rst_i = 1'b0;
        #1 check(mcu_rst_o, "mcu_rst_before_clock", {31'd0, mcu_rst_o}, 1);
        @(negedge clk_i);
        check(!mcu_rst_o, "mcu_rst_after_release", {31'd0, mcu_rst_o}, 0);

        // Four bytes into the ROM half, no verify.
        run_session(17'h10000, 4, 1'b0, 32'hFF005AA5, 1'b0);
        check(mem[17'h10000] == 8'hA5, "mem_10000", {24'd0, mem[17'h10000]}, 32'hA5);
        check(mem[17'h10001] == 8'h5A, "mem_10001", {24'd0, mem[17'h10001]}, 32'h5A);
        check(mem[17'h10002] == 8'h00, "mem_10002", {24'd0, mem[17'h10002]}, 32'h00);
        check(mem[17'h10003] == 8'hFF, "mem_10003", {24'd0, mem[17'h10003]}, 32'hFF);

        // Address wrap at the top of the SRAM.
        run_session(17'h1FFFE, 3, 1'b0, 32'h00332211, 1'b0);
        check(mem[17'h1FFFE] == 8'h11, "mem_1fffe", {24'd0, mem[17'h1FFFE]}, 32'h11);
        check(mem[17'h1FFFF] == 8'h22, "mem_1ffff", {24'd0, mem[17'h1FFFF]}, 32'h22);
        check(mem[17'h00000] == 8'h33, "mem_00000", {24'd0, mem[17'h00000]}, 32'h33);

        // Verify against a stuck-low data bit 3.
        stuck_en = 1'b1;
        run_session(17'h10010, 1, 1'b1, 32'h00000008, 1'b1);
        repeat (3) @(negedge clk_i);
        check(ld_err_o, "err_sticky_in_idle", {31'd0, ld_err_o}, 1);
        run_session(17'h10011, 2, 1'b1, 32'h00000201, 1'b0);
        check(!ld_err_o, "err_clear_after_restart", {31'd0, ld_err_o}, 0);
        stuck_en = 1'b0;

        // Handshake: start with a coincident byte, idle WAIT, start while busy.
        exp_done_q.push_back(1'b0);
        wq.push_back({17'h00100, 8'h3C});
        wq.push_back({17'h00101, 8'hC3});
        do_start(17'h00100, 17'd2, 1'b0, 1'b1);
        snap_we  = we_total;
        snap_oe  = oe_total;
        rdy_held = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (!ld_rdy_o) rdy_held = 1'b0;
        end
        check(rdy_held, "rdy_held_in_wait", {31'd0, rdy_held}, 1);
        check(we_total == snap_we, "no_strobe_in_wait", we_total - snap_we, 0);
        ld_start_i  = 1'b1;
        ld_base_i17 = 17'h05555;
        ld_len_i17  = 17'd7;
        ld_verify_i = 1'b1;
        @(posedge clk_i);
        #1 ld_start_i = 1'b0;
        send(8'h3C, GAP_NV, 1'b0);
        send(8'hC3, GAP_NV, 1'b1);
        finish_session(GAP_NV);
        check(oe_total == snap_oe, "busy_start_ignored", oe_total - snap_oe, 0);

        // Empty session.
        snap_we = we_total;
        snap_oe = oe_total;
        exp_done_q.push_back(1'b0);
        do_start(17'h12345, 17'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        check(ld_done_o && ld_busy_o, "len0_done", {30'd0, ld_done_o, ld_busy_o}, 32'h3);
        @(negedge clk_i);
        check(!ld_done_o && !ld_busy_o, "len0_idle", {30'd0, ld_done_o, ld_busy_o}, 0);
        check((we_total == snap_we) && (oe_total == snap_oe), "len0_no_strobes",
              (we_total - snap_we) + (oe_total - snap_oe), 0);
        check(exp_done_q.size() == 0, "len0_done_seen", exp_done_q.size(), 0);

        // Reset in the middle of a write.
        do_start(17'h00200, 17'd1, 1'b0, 1'b0);
        send(8'h77, GAP_NV, 1'b0);
        n = 0;
        while (sram_we_no && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check(!sram_we_no, "reached_write", n, 0);
        #2 rst_i = 1'b1;
        #1;
        check(sram_we_no && !sram_dat_oe_o, "async_rst_strobes",
              {30'd0, sram_we_no, sram_dat_oe_o}, 32'h2);
        check_reset_values();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check(!mcu_rst_o && !ld_busy_o, "post_rst_idle", {30'd0, mcu_rst_o, ld_busy_o}, 0);
        repeat (3) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_loader.md
# sram_loader

Host-side SRAM programming engine for the CPLD. It holds the 8051 in reset and takes a byte stream over a valid/ready handshake. Each byte is written into the external 128 KB SRAM at consecutive 17-bit addresses. The usual target is the ROM half (0x10000–0x1FFFF) that the MCU later fetches from via PSEN. An optional read-back verify flags any mismatch.

## Interface
Parameters:
- WE_CYCLES, 2, number of clocks sram_we_no is held low per byte (≥1)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- ld_start_i  in  1  one-cycle pulse that starts a load session; ignored while busy
- ld_base_i17  in  17  first SRAM address, latched on ld_start_i
- ld_len_i17  in  17  byte count, latched on ld_start_i; 0 means empty session
- ld_verify_i  in  1  latched on ld_start_i; 1 enables read-back compare per byte
- ld_vld_i  in  1  input byte valid
- ld_dat_i8  in  8  input byte
- ld_rdy_o  out  1  loader ready for a byte
- ld_busy_o  out  1  session in progress
- ld_done_o  out  1  one-cycle pulse at end of session
- ld_err_o  out  1  sticky verify mismatch, cleared on accepted ld_start_i
- mcu_rst_o  out  1  MCU reset request, high while loading
- sram_addr_o17  out  17  SRAM address
- sram_dat_o8  out  8  SRAM write data
- sram_dat_oe_o  out  1  1 drives sram_dat_o8 onto the SRAM bus at the top level
- sram_dat_i8  in  8  SRAM read data
- sram_we_no  out  1  SRAM write enable, active low
- sram_oe_no  out  1  SRAM output enable, active low

## Operation
- All outputs are registered and valid for the whole cycle the FSM occupies the named state.
- States:
  - IDLE
  - WAIT: ld_rdy_o=1
  - SETUP
  - WRITE: sram_we_no=0 for WE_CYCLES clocks
  - HOLD
  - VREAD: sram_oe_no=0 for 2 clocks
  - VCMP
  - NEXT
  - DONE
- IDLE:
  - Accepted ld_start_i latches base, len and verify, and clears ld_err_o.
  - If len=0, go to DONE; otherwise go to WAIT.
- WAIT:
  - Transfer occurs when ld_vld_i & ld_rdy_o at a clock edge.
  - The byte is latched, and the FSM moves to SETUP.
  - WAIT persists indefinitely with no timeout.
- SETUP: address and data are driven, sram_dat_oe_o=1, both strobes high.
- WRITE: we_n low; address, data and dat_oe are stable.
- HOLD: we_n high; data and dat_oe are still driven, giving one clock of data hold after the WE rising edge.
- After HOLD:
  - With verify, go to VREAD. In VREAD, dat_oe=0, oe_n low, and sram_dat_i8 is registered on the 2nd VREAD edge. VCMP then sets ld_err_o if the read byte ≠ the written byte.
  - Without verify, go directly to NEXT.
- NEXT:
  - Address +1, wrapping modulo 2^17 (0x1FFFF → 0x00000). Remaining count −1.
  - Go to DONE if remaining = 0, else WAIT.
- DONE: ld_done_o=1 for one cycle, then IDLE.
- ld_busy_o=1 in every state except IDLE.
- mcu_rst_o=1 in every state except IDLE.
- sram_we_no and sram_oe_no are never low in the same cycle.
- dat_oe=0 whenever oe_n=0.
- ld_err_o holds its value through DONE/IDLE until the next accepted start.

## Timing
- Reset values:
  - 0: ld_rdy_o, ld_busy_o, ld_done_o, ld_err_o, sram_addr_o17, sram_dat_o8, sram_dat_oe_o
  - 1: sram_we_no, sram_oe_no, mcu_rst_o
- mcu_rst_o drops on the first clock after rst_i release.
- Start → ld_rdy_o high: 1 cycle.
- Byte period, accept edge to next WAIT: WE_CYCLES+3 clocks without verify (5 at default), WE_CYCLES+6 with verify (8 at default).
- Last byte's NEXT → ld_done_o: next cycle. ld_done_o → IDLE (busy=0, mcu_rst_o=0): next cycle.
- len=0: start edge, then DONE one cycle, then IDLE.
- ld_start_i while busy: no effect on latched values or ld_err_o.
- ld_start_i and ld_vld_i in the same IDLE cycle: the byte is not accepted, because rdy=0.
- rst_i mid-write: we_n returns to 1 and dat_oe to 0 immediately (asynchronous); the session is abandoned.

## Test plan
- Reset: assert rst_i mid-WRITE → sram_we_no=1 and sram_dat_oe_o=0 before the next clock; all outputs at reset values; mcu_rst_o=0 one clock after release.
- Start base=0x10000, len=4, verify=0; stream 0xA5, 0x5A, 0x00, 0xFF back-to-back → SRAM model holds the bytes at 0x10000–0x10003; consecutive accepts 5 clocks apart; we_n low exactly 2 clocks per byte; done pulse 1 cycle; mcu_rst_o high throughout the session.
- Wrap: base=0x1FFFE, len=3 → writes land at 0x1FFFE, 0x1FFFF, 0x00000.
- Verify with stuck bit: model forces data bit 3 to 0; write 0x08 with verify=1 → ld_err_o=1 after VCMP and stays 1 past done. Next start clears it. Write 0x01 → ld_err_o stays 0.
- Handshake: ld_vld_i low for 10 cycles in WAIT → no strobes, rdy held. Also, a start pulse during busy → base/len unchanged, session completes normally.
- len=0 → done pulse one cycle after start, busy for 1 cycle, no SRAM strobes.
